fsk_demod: RTL
==============

FSK_DEMOD -- requirements
Module: fsk_demod

Interface
REQ-001 Parameter BIT_CYCLES, default 64: clk cycles per data bit window.
REQ-002 Parameter THRESH, default 4: bit is 1 when window edge count > THRESH.
REQ-003 Parameter CNT_W, default 6: edge counter width.
REQ-004 Parameter WORD_W, default 16: bits per assembled word.
REQ-005 Parameter SYNC_WORD, default 16'hA5C3, WORD_W bits: frame sync pattern.
REQ-006 clk  input  1  single system clock; all logic on posedge clk.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 en  input  1  demodulator enable; 0 = idle.
REQ-009 data_in  input  1  asynchronous 2-FSK signal.
REQ-010 bit_out  output  1  last demodulated bit.
REQ-011 bit_valid  output  1  one-cycle strobe, bit_out updated.
REQ-012 word_out  output  WORD_W  last assembled word, MSB = first received bit.
REQ-013 word_valid  output  1  one-cycle strobe, word_out updated.
REQ-014 locked  output  1  high while state is RECV.

Function
REQ-015 data_in SHALL pass a 2-flop synchronizer; a rising edge is detected when sync stage 2 = 1 and stage 3 = 0.
REQ-016 Bit timer SHALL count 0..BIT_CYCLES-1 while en=1, wrapping to 0; cycle BIT_CYCLES-1 is the window boundary.
REQ-017 Edge counter SHALL increment per detected edge, saturate at 2^CNT_W-1, never wrap.
REQ-018 At boundary: bit = (count + edge detected this cycle) > THRESH; counter SHALL clear to 0 next cycle (boundary-cycle edge belongs to closing window).
REQ-019 bit_out and bit_valid SHALL register the cycle after the boundary; bit_valid high exactly one cycle per window.
REQ-020 Each new bit SHALL shift into a WORD_W shift register (LSB in) and a received-bit counter.
REQ-021 States: IDLE, HUNT, RECV. en=0 forces IDLE from any state; IDLE->HUNT when en=1.
REQ-022 HUNT: when shift register including new bit equals SYNC_WORD, go RECV, clear received-bit counter; no word_valid for the sync word.
REQ-023 RECV: after WORD_W bits, word_out = shift register, word_valid pulses with that bit's bit_valid, state returns to HUNT.
REQ-024 en=0 SHALL clear bit timer, edge counter, shift register and bit counter; bit_out and word_out hold; strobes 0.
REQ-025 en 0->1 SHALL start a fresh window at timer 0.

Reset
REQ-026 rst=1 SHALL asynchronously set state IDLE and clear synchronizer, counters, shift register, bit_out, bit_valid, word_out, word_valid, locked to 0.
REQ-027 rst asserted mid-word SHALL discard the partial word; no word_valid on release.
REQ-028 First window after rst release with en=1 SHALL begin at timer 0.

Configuration
REQ-029 Macro FSK_SYNC_DET_EN defined: HUNT state and SYNC_WORD matching as in REQ-022/023.
REQ-030 FSK_SYNC_DET_EN undefined: IDLE->RECV directly, free-running words every WORD_W bits, RECV stays RECV; SYNC_WORD unused; locked = en.

Verification
REQ-031 Defaults, en=1, data_in period 8 clk for one window -> bit_valid pulse, bit_out=1 (7-8 edges > 4).
REQ-032 data_in period 32 clk for one window -> bit_out=0 (2 edges).
REQ-033 Macro on: send 0xA5C3 then 0x1234 MSB-first -> locked rises after 16th sync bit; word_out=0x1234, word_valid one cycle; state back to HUNT.
REQ-034 Macro on: send 0x1234 without sync -> locked=0, no word_valid.
REQ-035 data_in period 2 clk, CNT_W=3 -> counter saturates at 7, bit_out=1, no wrap to 0.
REQ-036 rst pulse after 8 bits of word -> all outputs 0; next word_valid only after full sync+16 bits (macro on) or 16 fresh bits (macro off).

Source files
------------

// File: rtl/fsk_demod.sv
// 2-FSK demodulator: counts rising edges per bit window, slices against THRESH, frames words.
// Define FSK_SYNC_DET_EN to hunt for SYNC_WORD before each word; otherwise words free-run.
module fsk_demod #(
   parameter int                BIT_CYCLES = 64,
   parameter int                THRESH     = 4,
   parameter int                CNT_W      = 6,
   parameter int                WORD_W     = 16,
   parameter logic [WORD_W-1:0] SYNC_WORD  = 16'hA5C3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              data_in,
   output logic              bit_out,
   output logic              bit_valid,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   output logic              locked
);
   localparam int TW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int RW = $clog2(WORD_W + 1);
   localparam logic [TW-1:0]    T_LAST = TW'(BIT_CYCLES - 1);
   localparam logic [RW-1:0]    R_LAST = RW'(WORD_W - 1);
   localparam logic [CNT_W-1:0] C_MAX  = '1;
   localparam logic [CNT_W:0]   THR    = (CNT_W + 1)'(THRESH);

   typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;

   logic [2:0]        sync;
   logic              edge_det;
   logic              at_bnd;
   logic              bit_now;
   logic [TW-1:0]     timer;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W:0]    sum;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_nx;
   logic [RW-1:0]     rx_cnt;
   state_t            state;

   // sync[1:0] is the metastability pair; sync[2] only delays for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= '0;
      else     sync <= {sync[1:0], data_in};
   end

   assign edge_det = sync[1] & ~sync[2];
   assign at_bnd   = en && (timer == T_LAST);
   assign sum      = {1'b0, cnt} + {{CNT_W{1'b0}}, edge_det};
   assign bit_now  = sum > THR;
   assign shreg_nx = {shreg[WORD_W-2:0], bit_now};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
         cnt   <= '0;
      end else if (!en) begin
         timer <= '0;
         cnt   <= '0;
      end else begin
         timer <= at_bnd ? '0 : timer + 1'b1;
         // a boundary-cycle edge is already folded into sum, so clearing loses nothing
         if (at_bnd)
            cnt <= '0;
         else if (edge_det && (cnt != C_MAX))
            cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         rx_cnt     <= '0;
         bit_out    <= 1'b0;
         bit_valid  <= 1'b0;
         word_out   <= '0;
         word_valid <= 1'b0;
      end else begin
         bit_valid  <= 1'b0;
         word_valid <= 1'b0;
         if (!en) begin
            state  <= IDLE;
            shreg  <= '0;
            rx_cnt <= '0;
         end else begin
            if (state == IDLE) begin
`ifdef FSK_SYNC_DET_EN
               state <= HUNT;
`else
               state <= RECV;
`endif
            end
            if (at_bnd) begin
               bit_out   <= bit_now;
               bit_valid <= 1'b1;
               shreg     <= shreg_nx;
               case (state)
`ifdef FSK_SYNC_DET_EN
                  HUNT: begin
                     if (shreg_nx == SYNC_WORD) begin
                        state  <= RECV;
                        rx_cnt <= '0;
                     end
                  end
`endif
                  RECV: begin
                     if (rx_cnt == R_LAST) begin
                        word_out   <= shreg_nx;
                        word_valid <= 1'b1;
                        rx_cnt     <= '0;
`ifdef FSK_SYNC_DET_EN
                        state      <= HUNT;
`endif
                     end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

`ifdef FSK_SYNC_DET_EN
   assign locked = (state == RECV);
`else
   logic unused_sync;
   assign unused_sync = ^SYNC_WORD;
   assign locked = en & ~rst;
`endif

endmodule
